// File: rtl/vga_pixel_if.sv
// rtl/vga_pixel_if.sv - cell inputs, timing inputs and RGB/sync outputs of the pixel serializer
interface vga_pixel_if;
  logic [7:0] vdata;
  logic [7:0] fdata;
  logic       pload_n;
  logic       shload_n;
  logic       blank_in;
  logic       hsync_in_n;
  logic       vsync_in_n;
  logic [1:0] red;
  logic [1:0] green;
  logic [1:0] blue;
  logic       hsync_n;
  logic       vsync_n;

  modport master (
    output vdata, fdata, pload_n, shload_n, blank_in, hsync_in_n, vsync_in_n,
    input  red, green, blue, hsync_n, vsync_n
  );

  modport slave (
    input  vdata, fdata, pload_n, shload_n, blank_in, hsync_in_n, vsync_in_n,
    output red, green, blue, hsync_n, vsync_n
  );
endinterface

// File: rtl/vga_pixel.sv
// rtl/vga_pixel.sv - VGA pixel serializer: font shift, IRGB colour map, sync delay
// Optional attribute blink enabled by defining VGA_BLINK_EN.
module vga_pixel #(
  parameter int SYNC_DLY   = 2,
  parameter int BLINK_LOG2 = 4
) (
  input logic         pclk,
  input logic         rst_n,
  vga_pixel_if.slave  bus
);

  logic [7:0]          shreg;
  logic [7:0]          attr_pend;
  logic [7:0]          attr_act;
  logic [SYNC_DLY-1:0] blank_dly;
  logic [SYNC_DLY-1:0] hs_dly;
  logic [SYNC_DLY-1:0] vs_dly;
  logic [3:0]          fg;
  logic [3:0]          bg;
  logic [3:0]          irgb;
  logic [5:0]          rgb_map;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      attr_pend <= 8'h00;
    end else if (!bus.pload_n) begin
      attr_pend <= bus.vdata;
    end
  end

  // attr_act takes the pre-edge attr_pend, so a same-edge pload never bypasses into the cell
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= 8'h00;
      attr_act <= 8'h00;
    end else if (!bus.shload_n) begin
      shreg    <= bus.fdata;
      attr_act <= attr_pend;
    end else begin
      shreg    <= {shreg[6:0], 1'b0};
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      blank_dly <= '1;
      hs_dly    <= '1;
      vs_dly    <= '1;
    end else begin
      blank_dly <= {blank_dly[SYNC_DLY-2:0], bus.blank_in};
      hs_dly    <= {hs_dly[SYNC_DLY-2:0], bus.hsync_in_n};
      vs_dly    <= {vs_dly[SYNC_DLY-2:0], bus.vsync_in_n};
    end
  end

`ifdef VGA_BLINK_EN
  logic                vs_prev;
  logic [BLINK_LOG2:0] frame_cnt;
  logic                blink_phase;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev   <= 1'b1;
      frame_cnt <= '0;
    end else begin
      vs_prev <= bus.vsync_in_n;
      if (vs_prev && !bus.vsync_in_n) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign blink_phase = frame_cnt[BLINK_LOG2];

  always_comb begin
    bg = {1'b0, attr_act[6:4]};
    fg = attr_act[3:0];
    if (attr_act[7] && blink_phase) begin
      fg = bg;
    end
  end
`else
  always_comb begin
    bg = attr_act[7:4];
    fg = attr_act[3:0];
  end
`endif

  assign irgb = shreg[7] ? fg : bg;

  // Intensity alone would be black under {C, C&I}; it is shown as dark grey instead
  always_comb begin
    rgb_map = {irgb[2], irgb[2] & irgb[3],
               irgb[1], irgb[1] & irgb[3],
               irgb[0], irgb[0] & irgb[3]};
    if (irgb == 4'b1000) begin
      rgb_map = 6'b01_01_01;
    end
  end

  // Blank is tapped one stage early so it meets the registered pixel on the same edge as the syncs
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      bus.red   <= 2'b00;
      bus.green <= 2'b00;
      bus.blue  <= 2'b00;
    end else if (blank_dly[SYNC_DLY-2]) begin
      bus.red   <= 2'b00;
      bus.green <= 2'b00;
      bus.blue  <= 2'b00;
    end else begin
      bus.red   <= rgb_map[5:4];
      bus.green <= rgb_map[3:2];
      bus.blue  <= rgb_map[1:0];
    end
  end

  assign bus.hsync_n = hs_dly[SYNC_DLY-1];
  assign bus.vsync_n = vs_dly[SYNC_DLY-1];

endmodule

// File: doc/vga_pixel.md
Name: vga_pixel

Overview:
- Pixel serializer stage directly downstream of the VGA timing/VRAM controller.
- Each 8-pixel character cell is assembled from three inputs:
  - the attribute byte read from VRAM during the colour phase;
  - the font-ROM row byte (character code latched externally, addressed with crow);
  - the cell load strobe.
- Shifts the font row out MSB-first at pclk rate, maps each bit to foreground/background IRGB colour, and drives 2-bit-per-channel RGB.
- Delays blank and syncs so they stay aligned with the pixel stream.

Parameters:
- SYNC_DLY, 2, pclk cycles of delay applied to blank/hsync/vsync; must equal the pixel pipeline depth.
- BLINK_LOG2, 4, log2 of frames per blink half-period; used only with the optional feature.

Ports:
- pclk  input  1  pixel clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- vdata  input  8  VRAM data bus; attribute byte while pload_n low
- fdata  input  8  font ROM row bits; bit 7 = leftmost pixel
- pload_n  input  1  low: attribute byte valid on vdata
- shload_n  input  1  low for one cycle per cell: load new cell
- blank_in  input  1  blanking from timing stage
- hsync_in_n  input  1  hsync from timing stage
- vsync_in_n  input  1  vsync from timing stage
- red  output  2  red level
- green  output  2  green level
- blue  output  2  blue level
- hsync_n  output  1  delayed hsync
- vsync_n  output  1  delayed vsync

Behaviour:
- Reset (async, rst_n low):
  - shift register = 0; attr_pend = 0; attr_act = 0.
  - red, green, blue = 0.
  - hsync_n = 1, vsync_n = 1.
  - Sync delay lines fill with blank = 1, syncs = 1.
  - Blink counter = 0.
- Attribute capture: on each edge with pload_n == 0, attr_pend <= vdata. pload_n may stay low for several cycles; the last sampled value wins.
- Cell load: on an edge with shload_n == 0:
  - shreg <= fdata; attr_act <= attr_pend.
  - Load has priority over shift.
  - If pload_n is also low on that edge, attr_act takes the old attr_pend (no bypass).
- Shift: otherwise shreg <= {shreg[6:0], 1'b0}. After 8 shifts without a load, output is background.
- Pixel select: pix = shreg[7]. Colour = attr_act[3:0] when pix is 1 (fg), else attr_act[7:4] (bg). Colour format is IRGB, bit 3 = I.
- Colour map, per channel C with intensity I:
  - level = {C, C & I}.
  - Special case IRGB = 4'b1000: all channels = 2'b01 (dark grey).
  - 4'b0000 gives black; 4'b1111 gives 2'b11 on all channels.
- Output register: red/green/blue <= mapped colour, or 0 when the delayed blank is 1.
- Latency:
  - fdata loaded at edge N appears as the first pixel on the outputs after edge N+1.
  - blank_in, hsync_in_n and vsync_in_n are each delayed exactly SYNC_DLY edges.
- No handshake back to the timing stage. The block assumes shload_n is asserted every 8 cycles; with no assertion, background continues (not an error).

Optional Feature:
- Macro VGA_BLINK_EN.
- Defined:
  - A frame counter of BLINK_LOG2+1 bits increments on each synchronously detected falling edge of vsync_in_n, using a registered previous value that resets to 1. The counter wraps.
  - blink_phase = counter MSB.
  - attr_act[7] becomes a blink flag; the background then uses {1'b0, attr_act[6:4]}.
  - When the flag is set and blink_phase == 1, foreground pixels show the background colour.
- Undefined: attr bit 7 is background intensity; no counter logic is synthesized.

Test Plan:
- Reset, then release with all inputs idle -> rgb = 0, hsync_n = vsync_n = 1 until the delay lines flush.
- pload_n low with vdata = 8'h1E, then shload_n low with fdata = 8'hA5, blank_in = 0 -> over the next 8 pixels, starting one edge after the load:
  - fg pixels (font bits 1,0,1,0,0,1,0,1) show yellow, levels 11/11/00;
  - bg pixels show blue, levels 00/00/10.
- Attr 8'h80, fdata = 8'h00 -> all pixels 01/01/01 (without VGA_BLINK_EN).
- blank_in = 1 mid-cell with fdata = 8'hFF, attr 8'h0F -> rgb = 0 exactly 2 edges later; hsync_in_n pulse of 96 cycles -> hsync_n pulse of 96 cycles delayed by 2.
- shload_n and pload_n low on the same edge, with vdata = 8'h44 and attr_pend = 8'h07 -> cell uses 8'h07; the next cell uses 8'h44.
- VGA_BLINK_EN with attr 8'h9F, fdata = 8'hFF:
  - frames 0-15 show fg white;
  - frames 16-31 show bg blue (00/00/10);
  - the pattern repeats at frame 32.
